// File: rtl/mmio_pkg.sv
// Shared encodings, default address map and parameter sanity helpers for the MMIO port controller.
package mmio_pkg;

    typedef enum logic [1:0] {
        MNONE  = 2'b00,
        MWRITE = 2'b01,
        MREAD  = 2'b11
    } mem_cmd_e;

    localparam logic [8:0] DEF_IN_BASE   = 9'h140;
    localparam logic [8:0] DEF_OUT_BASE  = 9'h100;
    localparam logic [8:0] DEF_STAT_BASE = 9'h180;

    // Edges after reset release before change detection is trusted:
    // the release edge plus the two-flop synchronizer flush.
    localparam logic [1:0] SETTLE_DONE = 2'd3;

    function automatic bit windows_overlap(input int a, input int na, input int b, input int nb);
        return (a < b + nb) && (b < a + na);
    endfunction

endpackage

// File: rtl/mmio_sync.sv
// Two-flop synchronizer for a W-bit bundle of asynchronous inputs.
// Latency: 2 clk; no backpressure.
module mmio_sync #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mmio_port_ctrl.sv
// Memory-mapped input/output ports with change flags and a maskable interrupt.
// Latency: reads combinational, writes and irq take effect 1 clk later; no backpressure.
module mmio_port_ctrl
    import mmio_pkg::*;
#(
    parameter int               DATA_W    = 16,
    parameter int               ADDR_W    = 9,
    parameter int               N_IN      = 2,
    parameter int               N_OUT     = 2,
    parameter int               PORT_W    = 8,
    parameter logic [ADDR_W-1:0] IN_BASE   = ADDR_W'(DEF_IN_BASE),
    parameter logic [ADDR_W-1:0] OUT_BASE  = ADDR_W'(DEF_OUT_BASE),
    parameter logic [ADDR_W-1:0] STAT_BASE = ADDR_W'(DEF_STAT_BASE)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       mem_addr,
    input  logic [1:0]              mem_cmd,
    input  logic [DATA_W-1:0]       wdata,
    output logic [DATA_W-1:0]       rdata,
    output logic                    rd_hit,
    input  logic [N_IN*PORT_W-1:0]  pin_in,
    output logic [N_OUT*PORT_W-1:0] pin_out,
    output logic                    irq
);

    if (N_IN < 1 || N_IN > 8 || N_OUT < 1 || N_OUT > 8 || PORT_W < 1 || PORT_W > DATA_W
        || N_IN > DATA_W) begin : g_bad_size
        $error("mmio_port_ctrl: port count or width out of range");
    end
    if (windows_overlap(int'(IN_BASE), N_IN, int'(OUT_BASE), N_OUT)
        || windows_overlap(int'(IN_BASE), N_IN, int'(STAT_BASE), 2)
        || windows_overlap(int'(OUT_BASE), N_OUT, int'(STAT_BASE), 2)) begin : g_bad_map
        $error("mmio_port_ctrl: address windows overlap");
    end

    logic [PORT_W-1:0] sync_q [N_IN];
    logic [PORT_W-1:0] prev_q [N_IN];
    logic [PORT_W-1:0] out_q  [N_OUT];
    logic [N_IN-1:0]   chg, ien, chg_set, chg_clr;
    logic [N_OUT-1:0]  out_we;
    logic [1:0]        settle_cnt;
    logic              wr, rd, stat_wr, ien_wr;
    logic              unused_wdata;

    for (genvar k = 0; k < N_IN; k++) begin : g_in
        mmio_sync #(.W(PORT_W)) u_sync (
            .clk   (clk),
            .reset (reset),
            .d     (pin_in[k*PORT_W +: PORT_W]),
            .q     (sync_q[k])
        );
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_out
        assign pin_out[k*PORT_W +: PORT_W] = out_q[k];
        assign out_we[k] = wr && (mem_addr == OUT_BASE + ADDR_W'(k));
    end

    assign wr           = (mem_cmd == MWRITE);
    assign rd           = (mem_cmd == MREAD);
    assign stat_wr      = wr && (mem_addr == STAT_BASE);
    assign ien_wr       = wr && (mem_addr == STAT_BASE + ADDR_W'(1));
    assign chg_clr      = stat_wr ? wdata[N_IN-1:0] : '0;
    assign unused_wdata = ^wdata;

    always_comb begin
        chg_set = '0;
        for (int k = 0; k < N_IN; k++) begin
            chg_set[k] = (settle_cnt == SETTLE_DONE) && (sync_q[k] != prev_q[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            settle_cnt <= '0;
            chg        <= '0;
            ien        <= '0;
            irq        <= 1'b0;
            for (int k = 0; k < N_IN; k++) prev_q[k] <= '0;
            for (int k = 0; k < N_OUT; k++) out_q[k] <= '0;
        end else begin
            if (settle_cnt != SETTLE_DONE) settle_cnt <= settle_cnt + 2'd1;
            for (int k = 0; k < N_IN; k++) prev_q[k] <= sync_q[k];
            // A same-cycle change beats the software clear.
            chg <= (chg & ~chg_clr) | chg_set;
            if (ien_wr) ien <= wdata[N_IN-1:0];
            irq <= |(chg & ien);
            for (int k = 0; k < N_OUT; k++) begin
                if (out_we[k]) out_q[k] <= wdata[PORT_W-1:0];
            end
        end
    end

    always_comb begin
        rdata  = '0;
        rd_hit = 1'b0;
        if (rd) begin
            for (int k = 0; k < N_IN; k++) begin
                if (mem_addr == IN_BASE + ADDR_W'(k)) begin
                    rd_hit = 1'b1;
                    rdata  = DATA_W'(sync_q[k]);
                end
            end
            for (int k = 0; k < N_OUT; k++) begin
                if (mem_addr == OUT_BASE + ADDR_W'(k)) begin
                    rd_hit = 1'b1;
                    rdata  = DATA_W'(out_q[k]);
                end
            end
            if (mem_addr == STAT_BASE) begin
                rd_hit = 1'b1;
                rdata  = DATA_W'(chg);
            end
            if (mem_addr == STAT_BASE + ADDR_W'(1)) begin
                rd_hit = 1'b1;
                rdata  = DATA_W'(ien);
            end
        end
    end

endmodule

// File: tb/tb_mmio_port_ctrl.sv
// Directed bench for mmio_port_ctrl with hand-computed expectations.
module tb_mmio_port_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  mem_addr;
    logic [1:0]  mem_cmd;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        rd_hit;
    logic [15:0] pin_in;
    logic [15:0] pin_out;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mmio_port_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .mem_addr (mem_addr),
        .mem_cmd  (mem_cmd),
        .wdata    (wdata),
        .rdata    (rdata),
        .rd_hit   (rd_hit),
        .pin_in   (pin_in),
        .pin_out  (pin_out),
        .irq      (irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_wr(input logic [8:0] a, input logic [15:0] d);
        mem_cmd  = 2'b01;
        mem_addr = a;
        wdata    = d;
        step();
        mem_cmd  = 2'b00;
        wdata    = 16'h0;
    endtask

    task automatic bus_rd(input string tag, input logic [8:0] a, input logic [15:0] exp,
                          input logic exp_hit);
        mem_cmd  = 2'b11;
        mem_addr = a;
        #2;
        chk({tag, "_data"}, 32'(rdata), 32'(exp));
        chk({tag, "_hit"}, 32'(rd_hit), 32'(exp_hit));
        mem_cmd  = 2'b00;
    endtask

    initial begin
        reset    = 1'b0;
        mem_cmd  = 2'b00;
        mem_addr = 9'h0;
        wdata    = 16'h0;
        pin_in   = 16'h0;
        step(3);
        chk("rst_pin_out", 32'(pin_out), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        bus_rd("rst_stat", 9'h180, 16'h0000, 1'b1);
        reset = 1'b1;
        step(4);

        // Output registers
        bus_wr(9'h100, 16'h00A5);
        chk("out0_pin", 32'(pin_out), 32'h00A5);
        bus_rd("out0_rd", 9'h100, 16'h00A5, 1'b1);
        bus_wr(9'h101, 16'h1234);
        chk("out1_pin", 32'(pin_out), 32'h34A5);
        bus_rd("out1_rd", 9'h101, 16'h0034, 1'b1);
        mem_addr = 9'h100;
        #1;
        chk("none_hit", 32'(rd_hit), 32'h0);
        chk("none_data", 32'(rdata), 32'h0);

        // Input synchronizer latency and change flag
        pin_in[15:8] = 8'h3C;
        bus_rd("in1_c0", 9'h141, 16'h0000, 1'b1);
        step();
        bus_rd("in1_c1", 9'h141, 16'h0000, 1'b1);
        step();
        bus_rd("in1_c2", 9'h141, 16'h003C, 1'b1);
        step();
        bus_rd("chg1", 9'h180, 16'h0002, 1'b1);
        bus_rd("in0", 9'h140, 16'h0000, 1'b1);
        bus_wr(9'h180, 16'h0002);
        bus_rd("chg1_clr", 9'h180, 16'h0000, 1'b1);

        // Interrupt enable and irq timing
        bus_wr(9'h181, 16'hFFFF);
        bus_rd("ien", 9'h181, 16'h0003, 1'b1);
        chk("irq_idle", 32'(irq), 32'h0);
        pin_in[7:0] = 8'h01;
        step(3);
        bus_rd("chg0", 9'h180, 16'h0001, 1'b1);
        chk("irq_pre", 32'(irq), 32'h0);
        step();
        chk("irq_set", 32'(irq), 32'h1);
        bus_wr(9'h180, 16'h0001);
        chk("irq_hold", 32'(irq), 32'h1);
        bus_rd("chg0_clr", 9'h180, 16'h0000, 1'b1);
        step();
        chk("irq_drop", 32'(irq), 32'h0);

        // Set beats clear in the same cycle
        pin_in[7:0] = 8'h00;
        step(2);
        bus_wr(9'h180, 16'h0001);
        bus_rd("set_wins", 9'h180, 16'h0001, 1'b1);
        bus_wr(9'h180, 16'h0003);
        bus_rd("clr_again", 9'h180, 16'h0000, 1'b1);

        // Unmapped and read-only addresses, reserved command
        bus_rd("miss", 9'h1FF, 16'h0000, 1'b0);
        bus_wr(9'h1FF, 16'hFFFF);
        chk("miss_pin_out", 32'(pin_out), 32'h34A5);
        bus_rd("miss_ien", 9'h181, 16'h0003, 1'b1);
        bus_rd("miss_stat", 9'h180, 16'h0000, 1'b1);
        bus_wr(9'h140, 16'hFFFF);
        bus_rd("in_wr_ign", 9'h140, 16'h0000, 1'b1);
        chk("in_wr_pin_out", 32'(pin_out), 32'h34A5);
        mem_cmd  = 2'b10;
        mem_addr = 9'h100;
        wdata    = 16'h0000;
        #1;
        chk("cmd10_hit", 32'(rd_hit), 32'h0);
        step();
        mem_cmd = 2'b00;
        chk("cmd10_pin_out", 32'(pin_out), 32'h34A5);

        // Reset beats a simultaneous write; no spurious flags on release
        pin_in   = 16'hFFFF;
        reset    = 1'b0;
        bus_wr(9'h101, 16'h00FF);
        chk("rst2_pin_out", 32'(pin_out), 32'h0);
        chk("rst2_irq", 32'(irq), 32'h0);
        step(2);
        bus_rd("rst2_stat", 9'h180, 16'h0000, 1'b1);
        bus_rd("rst2_ien", 9'h181, 16'h0000, 1'b1);
        reset = 1'b1;
        step(6);
        bus_rd("rel_stat", 9'h180, 16'h0000, 1'b1);
        chk("rel_irq", 32'(irq), 32'h0);
        bus_rd("rel_in1", 9'h141, 16'h00FF, 1'b1);
        pin_in[15:8] = 8'h00;
        step(3);
        bus_rd("post_rel_chg", 9'h180, 16'h0002, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_port_ctrl.md
MMIO_PORT_CTRL -- requirements
Module: mmio_port_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning CPU data bus width.
REQ-002 The block SHALL have parameter ADDR_W, default 9, meaning mem_addr width.
REQ-003 The block SHALL have parameter N_IN, default 2, range 1..8, meaning number of input ports.
REQ-004 The block SHALL have parameter N_OUT, default 2, range 1..8, meaning number of output ports.
REQ-005 The block SHALL have parameter PORT_W, default 8, range 1..DATA_W, meaning width of each port.
REQ-006 The block SHALL have parameter IN_BASE, default 9'h140, meaning input port 0 address; port k sits at IN_BASE+k.
REQ-007 The block SHALL have parameter OUT_BASE, default 9'h100, meaning output port 0 address; port k sits at OUT_BASE+k.
REQ-008 The block SHALL have parameter STAT_BASE, default 9'h180, meaning the status register address; the IRQ-enable register sits at STAT_BASE+1.
REQ-009 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-010 Port: reset  input  1  reset, synchronous and active-low.
REQ-011 Port: mem_addr  input  ADDR_W  CPU address.
REQ-012 Port: mem_cmd  input  2  CPU command: 00 = NONE, 11 = READ, 01 = WRITE; 10 is treated as NONE.
REQ-013 Port: wdata  input  DATA_W  CPU write data.
REQ-014 Port: rdata  output  DATA_W  read data; 0 when rd_hit = 0.
REQ-015 Port: rd_hit  output  1  high when a READ targets a mapped address in this block.
REQ-016 Port: pin_in  input  N_IN*PORT_W  asynchronous external inputs; port k occupies bits [k*PORT_W +: PORT_W].
REQ-017 Port: pin_out  output  N_OUT*PORT_W  output port registers.
REQ-018 Port: irq  output  1  interrupt request.

Function
REQ-019 Each input port SHALL pass through a 2-flop synchronizer, so pin_in reaches the synchronized value sync_k 2 clocks later.
REQ-020 A READ at IN_BASE+k SHALL return sync_k zero-extended to DATA_W, combinationally in the same cycle.
REQ-021 A READ at OUT_BASE+k SHALL return output register k, zero-extended.
REQ-022 A WRITE at OUT_BASE+k SHALL load wdata[PORT_W-1:0] into output register k at the next edge; pin_out SHALL be driven directly from these registers.
REQ-023 Change flag chg_k SHALL set on any cycle where sync_k differs from its previous-cycle value.
REQ-024 chg_k SHALL stay set until cleared.
REQ-025 A READ at STAT_BASE SHALL return {chg_N_IN-1..chg_0} in bits [N_IN-1:0], with all other bits 0.
REQ-026 A WRITE at STAT_BASE SHALL clear each chg_k whose wdata bit k = 1 (write-1-to-clear).
REQ-027 If a change and a clear on the same flag occur in the same cycle, the flag SHALL end set (set wins).
REQ-028 The IRQ-enable register ien[N_IN-1:0] at STAT_BASE+1 SHALL be read/write; unused bits SHALL read 0.
REQ-029 irq SHALL be registered: irq = |(chg & ien), updated every cycle, so it appears 1 clock after the flag or enable changes.
REQ-030 An address outside the map SHALL give rd_hit = 0 and rdata = 0 on READ, and SHALL change no state on WRITE.
REQ-031 A WRITE to an input-port address SHALL be ignored.
REQ-032 mem_cmd = NONE SHALL have no side effects.
REQ-033 Address windows SHALL be non-overlapping; overlap is a parameter error and SHALL be caught by an elaboration assertion.

Reset
REQ-034 While reset = 0 at a rising edge, the following SHALL clear to 0: all output registers, synchronizer flops, previous-value registers, chg, ien and irq.
REQ-035 Reset SHALL take priority over a simultaneous WRITE.
REQ-036 No change flag SHALL set on the first cycle after reset releases merely because inputs are nonzero; previous-value registers load sync on the first post-reset cycles, and transitions within the synchronizer flush are suppressed for 2 cycles.

Structure
REQ-037 Package mmio_pkg SHALL hold the mem_cmd encodings MNONE, MREAD and MWRITE, plus the default base-address constants.
REQ-038 One sub-module, mmio_sync, SHALL implement a parametrised-width 2-flop synchronizer, instanced once per input port.

Verification
REQ-039 Reset, then WRITE 0x00A5 to 0x100 -> pin_out[7:0] = 0xA5 next cycle; READ 0x100 -> rdata = 0x00A5, rd_hit = 1.
REQ-040 Drive pin_in port 1 = 0x3C -> READ 0x141 returns 0x003C from cycle 2 onward, 0x0000 before; chg_1 sets and READ 0x180 -> 0x0002.
REQ-041 With ien = 0x3, toggle port 0 -> irq = 1 one cycle after chg_0; WRITE 0x0001 to 0x180 -> chg_0 = 0 and irq drops next cycle.
REQ-042 Toggle port 0 in the same cycle as a W1C to 0x180 -> chg_0 remains 1.
REQ-043 READ 0x1FF and WRITE 0x1FF -> rd_hit = 0, rdata = 0, no register change; WRITE to 0x140 -> ignored.
REQ-044 Assert reset mid-operation with a WRITE 0x00FF to 0x101 -> pin_out = 0, chg = 0, irq = 0; pin_in held at 0xFF through release -> no chg set.
